// File: rtl/imem_port_arbiter_if.sv
// Bus bundle between the fetch unit, the debug reader, the instruction memory
// and imem_port_arbiter.
//   slave  : arbiter view (requests and mem_rd in; grants, read data, mem_addr out)
//   master : requester/memory view (mirror of slave)
// Signals:
//   cpu_req/cpu_addr        fetch request and word address
//   cpu_gnt/cpu_stall       fetch grant and PC-freeze (combinational)
//   cpu_rdata/cpu_rvalid    registered fetch data and its 1-cycle valid pulse
//   dbg_req/dbg_addr        debug read request and word address
//   dbg_lock                hold port ownership after the current debug grant
//   dbg_gnt                 debug grant (combinational)
//   dbg_rdata/dbg_rvalid    registered debug data and its 1-cycle valid pulse
//   lock_abort              1-cycle pulse when a debug lock is forcibly released
//   mem_addr/mem_rd         instruction memory address out / read word in
interface imem_port_arbiter_if #(
   parameter int unsigned AW = 6,
   parameter int unsigned DW = 32
) ();
   logic          cpu_req;
   logic [AW-1:0] cpu_addr;
   logic          cpu_gnt;
   logic          cpu_stall;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_rvalid;
   logic          dbg_req;
   logic [AW-1:0] dbg_addr;
   logic          dbg_lock;
   logic          dbg_gnt;
   logic [DW-1:0] dbg_rdata;
   logic          dbg_rvalid;
   logic          lock_abort;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_rd;

   modport slave (
      input  cpu_req, cpu_addr, dbg_req, dbg_addr, dbg_lock, mem_rd,
      output cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
             dbg_gnt, dbg_rdata, dbg_rvalid, lock_abort, mem_addr
   );

   modport master (
      output cpu_req, cpu_addr, dbg_req, dbg_addr, dbg_lock, mem_rd,
      input  cpu_gnt, cpu_stall, cpu_rdata, cpu_rvalid,
             dbg_gnt, dbg_rdata, dbg_rvalid, lock_abort, mem_addr
   );
endinterface

// File: rtl/imem_port_arbiter.sv
// Shares the single combinational read port of the instruction memory between
// CPU fetch and a debug/monitor reader. One requester is granted per cycle;
// the granted word is registered (latency 1) and the CPU is stalled whenever
// its fetch is denied. The debug side may lock the port for atomic multi-word
// read-back, bounded by LOCK_MAX cycles.
// Ports:
//   CLK    clock, all state updates on posedge
//   RESET  synchronous active-high reset
//   bus    imem_port_arbiter_if.slave (requests, grants, read data, memory port)
// Build option:
//   ARB_RR_EN defined   -> round-robin arbitration in S_IDLE, no starvation counter
//   ARB_RR_EN undefined -> fixed CPU priority with forced debug grant after
//                          STARVE_LIMIT consecutive denied debug cycles
module imem_port_arbiter #(
   parameter int unsigned AW           = 6,
   parameter int unsigned DW           = 32,
   parameter int unsigned STARVE_LIMIT = 8,
   parameter int unsigned LOCK_MAX     = 16
) (
   input  logic                 CLK,
   input  logic                 RESET,
   imem_port_arbiter_if.slave   bus
);

   localparam int unsigned LCW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
   localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_LOCK = 1'b1
   } state_e;

   state_e         state_q, state_d;
   logic [LCW-1:0] lock_cnt_q, lock_cnt_d;
   logic           lock_wait_q, lock_wait_d;   // forced release seen, dbg_lock not yet dropped
   logic           lock_abort_q, lock_abort_d;
   logic           cpu_gnt, dbg_gnt;
   logic [DW-1:0]  cpu_rdata_q, dbg_rdata_q;
   logic           cpu_rvalid_q, dbg_rvalid_q;

`ifdef ARB_RR_EN
   logic           prio_dbg_q, prio_dbg_d;     // 1: debug wins the next conflict
`else
   localparam int unsigned SCW = $clog2(STARVE_LIMIT + 1);
   logic [SCW-1:0] starve_cnt_q, starve_cnt_d;
`endif

   // Grant selection and next-state logic
   always_comb begin
      cpu_gnt     = 1'b0;
      dbg_gnt     = 1'b0;
      state_d     = state_q;
      lock_cnt_d  = lock_cnt_q;
      lock_wait_d = lock_wait_q;

      case (state_q)
         S_IDLE: begin
`ifdef ARB_RR_EN
            if (bus.cpu_req && bus.dbg_req) begin
               dbg_gnt = prio_dbg_q;
               cpu_gnt = ~prio_dbg_q;
            end else begin
               cpu_gnt = bus.cpu_req;
               dbg_gnt = bus.dbg_req;
            end
`else
            if (bus.dbg_req && (starve_cnt_q == SCW'(STARVE_LIMIT))) begin
               dbg_gnt = 1'b1;
            end else if (bus.cpu_req) begin
               cpu_gnt = 1'b1;
            end else begin
               dbg_gnt = bus.dbg_req;
            end
`endif
            lock_wait_d = lock_wait_q & bus.dbg_lock;
            if (dbg_gnt && bus.dbg_lock && !lock_wait_q) begin
               state_d    = S_LOCK;
               lock_cnt_d = '0;
            end
         end
         S_LOCK: begin
            // lock_abort_q is high exactly in the LOCK_MAX-th cycle of a lock
            if (lock_abort_q) begin
               state_d     = S_IDLE;
               lock_wait_d = bus.dbg_lock;
            end else begin
               dbg_gnt = bus.dbg_req;
               if (lock_cnt_q != LOCK_LAST) begin
                  lock_cnt_d = lock_cnt_q + LCW'(1);
               end
               if (!bus.dbg_lock) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      lock_abort_d = (state_d == S_LOCK) && (lock_cnt_d == LOCK_LAST);

`ifdef ARB_RR_EN
      prio_dbg_d = prio_dbg_q;
      if (cpu_gnt) begin
         prio_dbg_d = 1'b1;
      end else if (dbg_gnt) begin
         prio_dbg_d = 1'b0;
      end
`else
      starve_cnt_d = '0;
      if (bus.dbg_req && !dbg_gnt) begin
         starve_cnt_d = (starve_cnt_q == SCW'(STARVE_LIMIT)) ? starve_cnt_q
                                                             : starve_cnt_q + SCW'(1);
      end
`endif
   end

   // State, counters and registered read port
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q      <= S_IDLE;
         lock_cnt_q   <= '0;
         lock_wait_q  <= 1'b0;
         lock_abort_q <= 1'b0;
         cpu_rdata_q  <= '0;
         cpu_rvalid_q <= 1'b0;
         dbg_rdata_q  <= '0;
         dbg_rvalid_q <= 1'b0;
`ifdef ARB_RR_EN
         prio_dbg_q   <= 1'b0;
`else
         starve_cnt_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         lock_cnt_q   <= lock_cnt_d;
         lock_wait_q  <= lock_wait_d;
         lock_abort_q <= lock_abort_d;
         cpu_rvalid_q <= cpu_gnt;
         dbg_rvalid_q <= dbg_gnt;
         if (cpu_gnt) begin
            cpu_rdata_q <= bus.mem_rd;
         end
         if (dbg_gnt) begin
            dbg_rdata_q <= bus.mem_rd;
         end
`ifdef ARB_RR_EN
         prio_dbg_q   <= prio_dbg_d;
`else
         starve_cnt_q <= starve_cnt_d;
`endif
      end
   end

   assign bus.cpu_gnt    = cpu_gnt;
   assign bus.dbg_gnt    = dbg_gnt;
   assign bus.cpu_stall  = bus.cpu_req & ~cpu_gnt;
   assign bus.mem_addr   = dbg_gnt ? bus.dbg_addr : bus.cpu_addr;
   assign bus.cpu_rdata  = cpu_rdata_q;
   assign bus.cpu_rvalid = cpu_rvalid_q;
   assign bus.dbg_rdata  = dbg_rdata_q;
   assign bus.dbg_rvalid = dbg_rvalid_q;
   assign bus.lock_abort = lock_abort_q;

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Testbench for imem_port_arbiter: directed stimulus, a cycle-level reference
// model of the arbitration rules, and literal expectations for key scenarios.
module tb_imem_port_arbiter;
   localparam int unsigned AW           = 6;
   localparam int unsigned DW           = 32;
   localparam int unsigned STARVE_LIMIT = 8;
   localparam int unsigned LOCK_MAX     = 16;

   logic CLK = 1'b0;
   logic RESET;

   imem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   imem_port_arbiter #(
      .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .LOCK_MAX(LOCK_MAX)
   ) dut (
      .CLK   (CLK),
      .RESET (RESET),
      .bus   (bus)
   );

   always #5 CLK = ~CLK;

   logic [DW-1:0] mem [64];
   assign bus.mem_rd = mem[bus.mem_addr];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
      end
   endtask

   // Reference model state, expressed as "where are we" quantities
   bit            m_valid = 1'b0;
   bit            m_locked;
   int unsigned   m_lock_cycle;     // 1-based index of the current locked cycle
   int unsigned   m_denied;         // consecutive cycles debug asked and was refused
   bit            m_ignore_lock;
   bit            m_prio_dbg;
   logic [DW-1:0] m_cpu_rdata, m_dbg_rdata;
   bit            m_cpu_rvalid, m_dbg_rvalid;

   // Who owns the port this cycle: {cpu, dbg}
   function automatic logic [1:0] arb_model();
      if (m_locked) return (m_lock_cycle == LOCK_MAX) ? 2'b00 : {1'b0, bus.dbg_req};
`ifdef ARB_RR_EN
      if (bus.cpu_req && bus.dbg_req) return m_prio_dbg ? 2'b01 : 2'b10;
      return {bus.cpu_req, bus.dbg_req};
`else
      if (bus.dbg_req && m_denied == STARVE_LIMIT) return 2'b01;
      if (bus.cpu_req) return 2'b10;
      return {1'b0, bus.dbg_req};
`endif
   endfunction

   // Model advance at each active edge
   always @(posedge CLK) begin : mdl
      logic [1:0] g;
      if (RESET) begin
         m_valid       = 1'b1;
         m_locked      = 1'b0;
         m_lock_cycle  = 0;
         m_denied      = 0;
         m_ignore_lock = 1'b0;
         m_prio_dbg    = 1'b0;
         m_cpu_rdata   = '0;
         m_dbg_rdata   = '0;
         m_cpu_rvalid  = 1'b0;
         m_dbg_rvalid  = 1'b0;
      end else if (m_valid) begin
         g = arb_model();
         m_cpu_rvalid = g[1];
         m_dbg_rvalid = g[0];
         if (g[1]) m_cpu_rdata = mem[bus.cpu_addr];
         if (g[0]) m_dbg_rdata = mem[bus.dbg_addr];
         if (bus.dbg_req && !g[0]) begin
            if (m_denied < STARVE_LIMIT) m_denied++;
         end else begin
            m_denied = 0;
         end
         if (g[1]) m_prio_dbg = 1'b1;
         else if (g[0]) m_prio_dbg = 1'b0;
         if (m_locked) begin
            if (m_lock_cycle == LOCK_MAX) begin
               m_locked      = 1'b0;
               m_ignore_lock = bus.dbg_lock;
            end else if (!bus.dbg_lock) begin
               m_locked = 1'b0;
            end else begin
               m_lock_cycle++;
            end
         end else begin
            if (g[0] && bus.dbg_lock && !m_ignore_lock) begin
               m_locked     = 1'b1;
               m_lock_cycle = 1;
            end
            m_ignore_lock = m_ignore_lock && bus.dbg_lock;
         end
      end
   end

   // Every-cycle comparison against the model, mid-cycle
   always @(negedge CLK) begin : cmp
      logic [1:0] g;
      if (m_valid) begin
         g = arb_model();
         check("cpu_gnt",    32'(bus.cpu_gnt),    32'(g[1]));
         check("dbg_gnt",    32'(bus.dbg_gnt),    32'(g[0]));
         check("gnt_excl",   32'(bus.cpu_gnt & bus.dbg_gnt), 32'(0));
         check("cpu_stall",  32'(bus.cpu_stall),  32'(bus.cpu_req & ~g[1]));
         check("mem_addr",   32'(bus.mem_addr),   32'(g[0] ? bus.dbg_addr : bus.cpu_addr));
         check("cpu_rvalid", 32'(bus.cpu_rvalid), 32'(m_cpu_rvalid));
         check("dbg_rvalid", 32'(bus.dbg_rvalid), 32'(m_dbg_rvalid));
         check("cpu_rdata",  bus.cpu_rdata,       m_cpu_rdata);
         check("dbg_rdata",  bus.dbg_rdata,       m_dbg_rdata);
         check("lock_abort", 32'(bus.lock_abort), 32'(m_locked && m_lock_cycle == LOCK_MAX));
      end
   end

   task automatic cyc();
      @(posedge CLK);
      #1;
   endtask

   task automatic drive(input bit cr, input logic [AW-1:0] ca, input bit dr,
                        input logic [AW-1:0] da, input bit dl);
      bus.cpu_req  = cr;
      bus.cpu_addr = ca;
      bus.dbg_req  = dr;
      bus.dbg_addr = da;
      bus.dbg_lock = dl;
   endtask

   typedef struct packed {
      logic          cr;
      logic [AW-1:0] ca;
      logic          dr;
      logic [AW-1:0] da;
      logic          dl;
   } vec_t;

   vec_t vecs [12];

   initial begin
      int aborts;
      int abort_at;

      for (int i = 0; i < 64; i++) mem[i] = 32'hA5A5_0000 | 32'(i);
      mem[5] = 32'h2008_0005;
      vecs = '{
         '{1'b1, 6'd10, 1'b0, 6'd0,  1'b0},
         '{1'b1, 6'd11, 1'b1, 6'd20, 1'b0},
         '{1'b0, 6'd0,  1'b1, 6'd20, 1'b0},
         '{1'b1, 6'd12, 1'b1, 6'd21, 1'b1},
         '{1'b0, 6'd0,  1'b1, 6'd22, 1'b1},
         '{1'b1, 6'd13, 1'b1, 6'd23, 1'b1},
         '{1'b1, 6'd13, 1'b0, 6'd0,  1'b1},
         '{1'b1, 6'd13, 1'b1, 6'd24, 1'b0},
         '{1'b1, 6'd13, 1'b0, 6'd0,  1'b0},
         '{1'b0, 6'd0,  1'b0, 6'd0,  1'b0},
         '{1'b1, 6'd63, 1'b1, 6'd62, 1'b0},
         '{1'b0, 6'd0,  1'b0, 6'd0,  1'b0}
      };

      RESET = 1'b1;
      drive(0, 0, 0, 0, 0);
      cyc();
      cyc();
      RESET = 1'b0;
      @(negedge CLK);
      check("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 32'(0));
      check("rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'(0));
      check("rst_cpu_rdata",  bus.cpu_rdata, 32'h0);
      check("rst_lock_abort", 32'(bus.lock_abort), 32'(0));

      // Plain fetch of word 5
      cyc();
      drive(1, 5, 0, 0, 0);
      @(negedge CLK);
      check("fetch_gnt",   32'(bus.cpu_gnt),   32'(1));
      check("fetch_stall", 32'(bus.cpu_stall), 32'(0));
      cyc();
      drive(0, 0, 0, 0, 0);
      @(negedge CLK);
      check("fetch_rvalid", 32'(bus.cpu_rvalid), 32'(1));
      check("fetch_rdata",  bus.cpu_rdata, 32'h2008_0005);

      // Both sides requesting continuously
      cyc();
      drive(1, 1, 1, 7, 0);
`ifdef ARB_RR_EN
      // the last grant went to the CPU, so debug wins the first conflict
      for (int k = 0; k < 8; k++) begin
         @(negedge CLK);
         check("rr_dbg_gnt", 32'(bus.dbg_gnt), 32'((k % 2) == 0));
         check("rr_cpu_gnt", 32'(bus.cpu_gnt), 32'((k % 2) == 1));
         cyc();
      end
`else
      for (int k = 0; k < 18; k++) begin
         @(negedge CLK);
         check("starve_dbg_gnt", 32'(bus.dbg_gnt),   32'(k == 8 || k == 17));
         check("starve_stall",   32'(bus.cpu_stall), 32'(k == 8 || k == 17));
         cyc();
      end
`endif
      drive(0, 0, 0, 0, 0);
      cyc();

      // Locked read-back of words 0..2 while the CPU waits
      drive(0, 0, 1, 0, 1);
      @(negedge CLK);
      check("lock_first_gnt", 32'(bus.dbg_gnt), 32'(1));
      cyc();
      drive(1, 2, 1, 1, 1);
      @(negedge CLK);
      check("lock_cpu_blocked", 32'(bus.cpu_gnt), 32'(0));
      check("lock_rdata0", bus.dbg_rdata, 32'hA5A5_0000);
      cyc();
      drive(1, 2, 1, 2, 1);
      @(negedge CLK);
      check("lock_cpu_blocked", 32'(bus.cpu_gnt), 32'(0));
      check("lock_rdata1", bus.dbg_rdata, 32'hA5A5_0001);
      cyc();
      drive(1, 2, 0, 0, 0);
      @(negedge CLK);
      check("lock_cpu_blocked", 32'(bus.cpu_gnt), 32'(0));
      check("lock_rdata2", bus.dbg_rdata, 32'hA5A5_0002);
      cyc();
      @(negedge CLK);
      check("unlock_cpu_gnt", 32'(bus.cpu_gnt), 32'(1));
      cyc();

      // Lock held past LOCK_MAX
      drive(0, 0, 1, 9, 1);
      aborts   = 0;
      abort_at = -1;
      for (int k = 0; k < 20; k++) begin
         if (k == 1)  bus.cpu_req = 1'b1;
         if (k == 18) bus.cpu_req = 1'b0;
         if (k == 19) bus.cpu_req = 1'b1;
         @(negedge CLK);
         if (bus.lock_abort === 1'b1) begin
            aborts++;
            abort_at = k;
         end
         if (k == 17) check("after_abort_cpu_gnt", 32'(bus.cpu_gnt), 32'(1));
         if (k == 18) check("no_relock_dbg_gnt",   32'(bus.dbg_gnt), 32'(1));
         if (k == 19) check("no_relock_cpu_gnt",   32'(bus.cpu_gnt), 32'(1));
         cyc();
      end
      check("abort_count", 32'(aborts),   32'(1));
      check("abort_cycle", 32'(abort_at), 32'(16));
      drive(0, 0, 0, 0, 0);
      cyc();

      // Reset while a locked debug read is in flight
      drive(0, 0, 1, 3, 1);
      @(negedge CLK);
      check("pre_rst_dbg_gnt", 32'(bus.dbg_gnt), 32'(1));
      cyc();
      RESET = 1'b1;
      drive(0, 0, 0, 0, 1);
      cyc();
      RESET = 1'b0;
      drive(1, 4, 0, 0, 0);
      @(negedge CLK);
      check("post_rst_dbg_rvalid", 32'(bus.dbg_rvalid), 32'(0));
      check("post_rst_lock_abort", 32'(bus.lock_abort), 32'(0));
      check("post_rst_cpu_gnt",    32'(bus.cpu_gnt),    32'(1));
      cyc();

      // Mixed vector table, checked by the model
      foreach (vecs[i]) begin
         drive(vecs[i].cr, vecs[i].ca, vecs[i].dr, vecs[i].da, vecs[i].dl);
         cyc();
      end
      drive(0, 0, 0, 0, 0);
      cyc();
      cyc();
      @(negedge CLK);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
